// File: rtl/trace_buffer_if.sv
// Tracer write, vblank and renderer read signals between the trace buffer and its neighbours.
interface trace_buffer_if;
  localparam int unsigned COL_W    = 10;
  localparam int unsigned HEIGHT_W = 8;
  localparam int unsigned CNT_W    = 8;

  logic                store;
  logic [COL_W-1:0]    column;
  logic                side;
  logic [HEIGHT_W-1:0] height;
  logic                vblank_start;
  logic [COL_W-1:0]    rd_col;
  logic [HEIGHT_W-1:0] rd_height;
  logic                rd_side;
  logic                tracer_enable;
  logic                front_bank;
  logic                frame_swapped;
  logic                overrun;
  logic [CNT_W-1:0]    overrun_count;

  // Driving side: tracer, video timing and renderer.
  modport master (
    output store, column, side, height, vblank_start, rd_col,
    input  rd_height, rd_side, tracer_enable, front_bank,
           frame_swapped, overrun, overrun_count
  );

  // The trace buffer itself.
  modport slave (
    input  store, column, side, height, vblank_start, rd_col,
    output rd_height, rd_side, tracer_enable, front_bank,
           frame_swapped, overrun, overrun_count
  );
endinterface

// File: rtl/trace_buffer.sv
// Double-banked per-column {side, height} store: tracer fills the back bank,
// renderer reads the front bank, banks swap at vblank once a frame is complete.
module trace_buffer #(
  parameter int unsigned COLS = 640,
  parameter int unsigned MAXH = 240
) (
  input  logic          clk,
  input  logic          reset,
  trace_buffer_if.slave bus
);
  localparam int unsigned COL_W    = 10;
  localparam int unsigned HEIGHT_W = 8;
  localparam int unsigned ENTRY_W  = HEIGHT_W + 1;
  localparam int unsigned CNT_W    = 8;

  localparam logic [COL_W-1:0]    LAST_COL   = COL_W'(COLS - 1);
  localparam logic [HEIGHT_W-1:0] MAX_HEIGHT = HEIGHT_W'(MAXH);
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

  typedef enum logic {
    S_TRACE = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic                tracer_enable_q, tracer_enable_d;
  logic                front_bank_q,    front_bank_d;
  logic                front_valid_q,   front_valid_d;
  logic                frame_swapped_q, frame_swapped_d;
  logic                overrun_q,       overrun_d;
  logic [CNT_W-1:0]    overrun_count_q, overrun_count_d;
  logic [ENTRY_W-1:0]  rd_data_q,       rd_data_d;

  logic                wr_en_c;
  logic                wr_last_c;
  logic [HEIGHT_W-1:0] wr_height_c;

  // Column storage, bank index first; contents survive reset.
  logic [ENTRY_W-1:0] bank_mem [2][COLS];

  // Write qualification and height clamp.
  always_comb begin
    wr_en_c     = !reset && bus.store && (state_q == S_TRACE) && (bus.column <= LAST_COL);
    wr_last_c   = wr_en_c && (bus.column == LAST_COL);
    wr_height_c = (bus.height > MAX_HEIGHT) ? MAX_HEIGHT : bus.height;
  end

  // Tracer writes always land in the bank the renderer is not reading.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      bank_mem[~front_bank_q][bus.column] <= {bus.side, wr_height_c};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_TRACE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: last column ends the trace, vblank in WAIT starts the next one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TRACE: if (wr_last_c)        state_d = S_WAIT;
      S_WAIT:  if (bus.vblank_start) state_d = S_TRACE;
    endcase
  end

  // FSM outputs: swap on vblank in WAIT, overrun on vblank in TRACE.
  always_comb begin
    tracer_enable_d = (state_d == S_TRACE);
    front_bank_d    = front_bank_q;
    front_valid_d   = front_valid_q;
    frame_swapped_d = 1'b0;
    overrun_d       = 1'b0;
    overrun_count_d = overrun_count_q;
    if (bus.vblank_start && (state_q == S_WAIT)) begin
      front_bank_d    = ~front_bank_q;
      front_valid_d   = 1'b1;
      frame_swapped_d = 1'b1;
    end
    if (bus.vblank_start && (state_q == S_TRACE)) begin
      overrun_d = 1'b1;
      if (overrun_count_q != CNT_MAX) begin
        overrun_count_d = overrun_count_q + CNT_W'(1);
      end
    end
  end

  // Read path: front bank as it stands this cycle, blanked when invalid or out of range.
  always_comb begin
    rd_data_d = '0;
    if (front_valid_q && (bus.rd_col <= LAST_COL)) begin
      rd_data_d = bank_mem[front_bank_q][bus.rd_col];
    end
  end

  // Output and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tracer_enable_q <= 1'b0;
      front_bank_q    <= 1'b0;
      front_valid_q   <= 1'b0;
      frame_swapped_q <= 1'b0;
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
      rd_data_q       <= '0;
    end else begin
      tracer_enable_q <= tracer_enable_d;
      front_bank_q    <= front_bank_d;
      front_valid_q   <= front_valid_d;
      frame_swapped_q <= frame_swapped_d;
      overrun_q       <= overrun_d;
      overrun_count_q <= overrun_count_d;
      rd_data_q       <= rd_data_d;
    end
  end

  assign bus.tracer_enable = tracer_enable_q;
  assign bus.front_bank    = front_bank_q;
  assign bus.frame_swapped = frame_swapped_q;
  assign bus.overrun       = overrun_q;
  assign bus.overrun_count = overrun_count_q;
  assign bus.rd_height     = rd_data_q[HEIGHT_W-1:0];
  assign bus.rd_side       = rd_data_q[HEIGHT_W];

endmodule
